// File: rtl/fourier_synth_pkg.sv
// Shared definitions for the ramped Fourier synthesizer.
//   ramp_state_t : encodings reported on the ramp_state output
//   clog2()      : ceiling log2, used to size the adder tree
//   latency()    : sample-to-output latency for a given channel count
package fourier_synth_pkg;

  typedef enum logic [1:0] {
    RS_IDLE      = 2'd0,
    RS_RAMP_UP   = 2'd1,
    RS_ON        = 2'd2,
    RS_RAMP_DOWN = 2'd3
  } ramp_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

  // Multiply stage + tree levels + ramp stage + saturation stage.
  function automatic int latency(input int n);
    return clog2(n) + 3;
  endfunction

endpackage

// File: rtl/fs_ramp_ctrl.sv
// Soft-start / soft-stop envelope generator.
// Ports:
//   clk, aresetn  : clock, asynchronous active-low reset
//   ramp_enable   : 1 = ramp towards full scale, 0 = ramp towards zero
//   ramp_step     : level change per clock; 0 freezes level and state
//   level         : envelope, 0 .. 2^RAMP_WIDTH (RAMP_WIDTH+1 bits)
//   ramp_state    : IDLE / RAMP_UP / ON / RAMP_DOWN
module fs_ramp_ctrl
  import fourier_synth_pkg::*;
#(
  parameter int RAMP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  ramp_enable,
  input  logic [RAMP_WIDTH-1:0] ramp_step,
  output logic [RAMP_WIDTH:0]   level,
  output logic [1:0]            ramp_state
);

  localparam logic [RAMP_WIDTH:0] FULL = {1'b1, {RAMP_WIDTH{1'b0}}};

  ramp_state_t           r_state;
  logic [RAMP_WIDTH:0]   r_level;
  logic [RAMP_WIDTH+1:0] w_up_raw;
  logic [RAMP_WIDTH:0]   w_up;
  logic [RAMP_WIDTH:0]   w_dn;

  // Saturating increment / decrement candidates for the next level.
  assign w_up_raw = {1'b0, r_level} + {2'b00, ramp_step};
  assign w_up     = (w_up_raw >= {1'b0, FULL}) ? FULL : w_up_raw[RAMP_WIDTH:0];
  assign w_dn     = ({1'b0, ramp_step} >= r_level) ? '0 : (r_level - {1'b0, ramp_step});

  // IDLE and ON are hold states: leaving them costs one cycle with no level
  // change. Inside a ramp the direction follows ramp_enable immediately, so a
  // reversal continues from the current level without a jump.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= RS_IDLE;
      r_level <= '0;
    end else if (ramp_step != '0) begin
      case (r_state)
        RS_IDLE: begin
          r_level <= '0;
          if (ramp_enable) r_state <= RS_RAMP_UP;
        end
        RS_ON: begin
          r_level <= FULL;
          if (!ramp_enable) r_state <= RS_RAMP_DOWN;
        end
        RS_RAMP_UP, RS_RAMP_DOWN: begin
          if (ramp_enable) begin
            r_level <= w_up;
            r_state <= (w_up == FULL) ? RS_ON : RS_RAMP_UP;
          end else begin
            r_level <= w_dn;
            r_state <= (w_dn == '0) ? RS_IDLE : RS_RAMP_DOWN;
          end
        end
      endcase
    end
  end

  assign level      = r_level;
  assign ramp_state = r_state;

endmodule

// File: rtl/fourier_synthesizer_ramped.sv
// Weighted sum of N_CHANNELS DDS streams, scaled by a ramp envelope and
// saturated to DAC width.
// Ports:
//   clk, aresetn    : clock, asynchronous active-low reset
//   s_axis_tdata    : packed signed samples, channel 0 in the LSBs
//   s_axis_tvalid   : per-channel valid; an invalid channel contributes 0
//   s_axis_tready   : all ones out of reset
//   amplitude       : packed unsigned per-channel weights
//   ramp_enable     : envelope direction; ramp_step: envelope step per clock
//   sat_clear       : clears sat_flag (a same-cycle saturation wins)
//   ramp_state      : envelope FSM state
//   sat_flag        : sticky saturation indicator
//   m_axis_tdata    : DAC sample sign-extended to AXIS_TDATA_WIDTH
//   m_axis_tvalid   : high once the pipeline has filled after reset
module fourier_synthesizer_ramped
  import fourier_synth_pkg::*;
#(
  parameter int N_CHANNELS       = 4,
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int CFG_DATA_WIDTH   = 16,
  parameter int DAC_WIDTH        = 14,
  parameter int SHIFT            = 13,
  parameter int RAMP_WIDTH       = 16
) (
  input  logic                                   clk,
  input  logic                                   aresetn,
  input  logic [N_CHANNELS*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N_CHANNELS-1:0]                  s_axis_tvalid,
  output logic [N_CHANNELS-1:0]                  s_axis_tready,
  input  logic [N_CHANNELS*CFG_DATA_WIDTH-1:0]   amplitude,
  input  logic                                   ramp_enable,
  input  logic [RAMP_WIDTH-1:0]                  ramp_step,
  input  logic                                   sat_clear,
  output logic [1:0]                             ramp_state,
  output logic                                   sat_flag,
  output logic [AXIS_TDATA_WIDTH-1:0]            m_axis_tdata,
  output logic                                   m_axis_tvalid
);

  localparam int T     = clog2(N_CHANNELS);
  localparam int LAT   = latency(N_CHANNELS);
  localparam int PW    = AXIS_TDATA_WIDTH + CFG_DATA_WIDTH + 1;
  localparam int SUM_W = PW + T;
  localparam int SCL_W = SUM_W + RAMP_WIDTH + 2;

  localparam logic signed [SCL_W-1:0] C_MAX = SCL_W'((longint'(1) << (DAC_WIDTH - 1)) - 1);
  localparam logic signed [SCL_W-1:0] C_MIN = ~C_MAX;

  // Tree nodes live in one flat array: level 0 holds the products, the last
  // entry is the root. Every node is kept at SUM_W bits (sign-extended).
  function automatic int nodes_at(input int lvl);
    return (N_CHANNELS + (1 << lvl) - 1) >> lvl;
  endfunction

  function automatic int node_off(input int lvl);
    int o;
    o = 0;
    for (int k = 0; k < lvl; k++) o += nodes_at(k);
    return o;
  endfunction

  localparam int NODES = node_off(T + 1);
  localparam int ROOT  = NODES - 1;

  function automatic logic is_sat(input logic signed [SCL_W-1:0] v);
    return (v > C_MAX) || (v < C_MIN);
  endfunction

  function automatic logic [AXIS_TDATA_WIDTH-1:0] sat_dac(input logic signed [SCL_W-1:0] v);
    logic signed [DAC_WIDTH-1:0] d;
    if (v > C_MAX)      d = C_MAX[DAC_WIDTH-1:0];
    else if (v < C_MIN) d = C_MIN[DAC_WIDTH-1:0];
    else                d = v[DAC_WIDTH-1:0];
    return AXIS_TDATA_WIDTH'(d);
  endfunction

  logic signed [SUM_W-1:0]        r_node [NODES];
  logic signed [SCL_W-1:0]        r_scaled;
  logic [AXIS_TDATA_WIDTH-1:0]    r_tdata;
  logic                           r_sat;
  logic [LAT-1:0]                 r_vld_sr;
  logic [RAMP_WIDTH:0]            w_level;
  logic signed [RAMP_WIDTH+1:0]   w_lvl_s;
  logic signed [SCL_W-1:0]        w_ramp_prod;
  logic signed [SCL_W-1:0]        w_v;
  logic                           w_sat;

  assign s_axis_tready = {N_CHANNELS{aresetn}};

  fs_ramp_ctrl #(
    .RAMP_WIDTH (RAMP_WIDTH)
  ) u_ramp (
    .clk         (clk),
    .aresetn     (aresetn),
    .ramp_enable (ramp_enable),
    .ramp_step   (ramp_step),
    .level       (w_level),
    .ramp_state  (ramp_state)
  );

  // ---- Stage M: per-channel sample * unsigned amplitude ----
  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_mul
    logic signed [AXIS_TDATA_WIDTH-1:0] w_smp;
    logic signed [CFG_DATA_WIDTH:0]     w_amp;
    logic signed [PW-1:0]               w_prod;

    assign w_smp  = s_axis_tdata[c*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
    assign w_amp  = signed'({1'b0, amplitude[c*CFG_DATA_WIDTH +: CFG_DATA_WIDTH]});
    assign w_prod = PW'(w_smp) * PW'(w_amp);

    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn)              r_node[c] <= '0;
      else if (s_axis_tvalid[c]) r_node[c] <= SUM_W'(w_prod);
      else                       r_node[c] <= '0;
    end
  end

  // ---- Tree stages: one registered level of pairwise adds per clock ----
  for (genvar l = 1; l <= T; l++) begin : g_lvl
    for (genvar j = 0; j < nodes_at(l); j++) begin : g_node
      localparam int SRC = node_off(l - 1) + 2 * j;
      localparam int DST = node_off(l) + j;
      if (2 * j + 1 < nodes_at(l - 1)) begin : g_add
        always_ff @(posedge clk or negedge aresetn) begin
          if (!aresetn) r_node[DST] <= '0;
          else          r_node[DST] <= r_node[SRC] + r_node[SRC+1];
        end
      end else begin : g_pass
        // Odd leftover: delayed to keep all branches time-aligned.
        always_ff @(posedge clk or negedge aresetn) begin
          if (!aresetn) r_node[DST] <= '0;
          else          r_node[DST] <= r_node[SRC];
        end
      end
    end
  end

  // ---- Stage R: envelope scaling with the current level register ----
  assign w_lvl_s     = signed'({1'b0, w_level});
  assign w_ramp_prod = SCL_W'(r_node[ROOT]) * SCL_W'(w_lvl_s);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) r_scaled <= '0;
    else          r_scaled <= w_ramp_prod >>> RAMP_WIDTH;
  end

  // ---- Stage S: shift, saturate, sticky flag ----
  assign w_v   = r_scaled >>> SHIFT;
  assign w_sat = is_sat(w_v);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_tdata <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_tdata <= sat_dac(w_v);
      r_sat   <= w_sat | (r_sat & ~sat_clear);
    end
  end

  // Output valid rises once LAT clocks have passed since reset release.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) r_vld_sr <= '0;
    else          r_vld_sr <= {r_vld_sr[LAT-2:0], 1'b1};
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_vld_sr[LAT-1];
  assign sat_flag      = r_sat;

endmodule

// File: tb/tb_fourier_synthesizer_ramped.sv
// Directed bench for fourier_synthesizer_ramped with N=4, RAMP_WIDTH=8.
module tb_fourier_synthesizer_ramped;

  logic        clk;
  logic        aresetn;
  logic [63:0] s_axis_tdata;
  logic [3:0]  s_axis_tvalid;
  logic [3:0]  s_axis_tready;
  logic [63:0] amplitude;
  logic        ramp_enable;
  logic [7:0]  ramp_step;
  logic        sat_clear;
  logic [1:0]  ramp_state;
  logic        sat_flag;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;

  logic [15:0] smp [4];
  logic [15:0] amp [4];

  int checks = 0;
  int errors = 0;

  // Ramp script starting from ON at full level with ch0=1000, amp 8192.
  // Output lags the level register by two cycles: f(0/64/128/192/256) =
  // 0/250/500/750/1000.
  int r_en  [20] = '{0, 0, 0, 0,   0, 1, 1, 1, 0, 0, 1, 1, 1, 0, 1, 1,   1, 1, 0, 1};
  int r_stp [20] = '{64,64,64,200, 64,64,64,64,64,64,64,64,64,64,64,200, 64,0, 0, 64};
  int r_st  [20] = '{3, 3, 3, 0,   0, 1, 1, 1, 3, 0, 1, 1, 1, 3, 1, 2,   2, 2, 2, 2};
  int r_out [20] = '{1000,1000,1000,750, 500,0,0,0, 250,500,250,0, 0,250,500,250,
                     500,1000,1000,1000};

  for (genvar c = 0; c < 4; c++) begin : g_pack
    assign s_axis_tdata[c*16 +: 16] = smp[c];
    assign amplitude[c*16 +: 16]    = amp[c];
  end

  fourier_synthesizer_ramped #(
    .N_CHANNELS       (4),
    .AXIS_TDATA_WIDTH (16),
    .CFG_DATA_WIDTH   (16),
    .DAC_WIDTH        (14),
    .SHIFT            (13),
    .RAMP_WIDTH       (8)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .amplitude     (amplitude),
    .ramp_enable   (ramp_enable),
    .ramp_step     (ramp_step),
    .sat_clear     (sat_clear),
    .ramp_state    (ramp_state),
    .sat_flag      (sat_flag),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic [15:0] d, input logic [15:0] a, input logic [3:0] v);
    for (int c = 0; c < 4; c++) begin
      smp[c] = d;
      amp[c] = a;
    end
    s_axis_tvalid = v;
  endtask

  initial begin
    aresetn     = 1'b0;
    ramp_enable = 1'b0;
    ramp_step   = 8'd64;
    sat_clear   = 1'b0;
    set_all(16'd0, 16'd0, 4'b0000);
    smp[0] = 16'd1000;
    amp[0] = 16'd8192;
    s_axis_tvalid = 4'b0001;

    // Reset state and pipeline fill.
    repeat (3) tick();
    check("rst_tdata", {16'h0, m_axis_tdata}, 32'h0);
    check("rst_tvalid", {31'h0, m_axis_tvalid}, 32'h0);
    check("rst_state", {30'h0, ramp_state}, 32'h0);
    check("rst_sat", {31'h0, sat_flag}, 32'h0);
    check("rst_tready", {28'h0, s_axis_tready}, 32'h0);
    aresetn = 1'b1;
    #1;
    check("tready_on", {28'h0, s_axis_tready}, 32'hF);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("fill_tvalid", {31'h0, m_axis_tvalid}, 32'h0);
      check("fill_tdata", {16'h0, m_axis_tdata}, 32'h0);
    end
    tick();
    check("tvalid_up", {31'h0, m_axis_tvalid}, 32'h1);

    // Ramp up from IDLE, step 64.
    ramp_enable = 1'b1;
    tick(); check("up_state_a", {30'h0, ramp_state}, 32'd1);
    tick(); check("up_state_b", {30'h0, ramp_state}, 32'd1);
    tick(); check("up_out_0", {16'h0, m_axis_tdata}, 32'd0);
    tick(); check("up_out_250", {16'h0, m_axis_tdata}, 32'd250);
    tick(); check("up_out_500", {16'h0, m_axis_tdata}, 32'd500);
            check("up_state_on", {30'h0, ramp_state}, 32'd2);
    tick(); check("up_out_750", {16'h0, m_axis_tdata}, 32'd750);
    tick(); check("up_out_1000", {16'h0, m_axis_tdata}, 32'd1000);
            check("on_tvalid", {31'h0, m_axis_tvalid}, 32'h1);

    // ch1 valid toggling, ch0 off: output follows 5 cycles later.
    set_all(16'd0, 16'd0, 4'b0000);
    smp[1] = 16'd2000;
    amp[1] = 16'd8192;
    for (int i = 0; i < 12; i++) begin
      s_axis_tvalid = {2'b00, (i % 2 == 0), 1'b0};
      tick();
      if (i >= 4)
        check("toggle_out", {16'h0, m_axis_tdata}, ((i - 4) % 2 == 0) ? 32'd2000 : 32'd0);
    end

    // Saturation both ways, then clear.
    set_all(16'h7FFF, 16'hFFFF, 4'b1111);
    repeat (5) tick();
    check("sat_pos_out", {16'h0, m_axis_tdata}, 32'h1FFF);
    check("sat_pos_flag", {31'h0, sat_flag}, 32'h1);
    set_all(16'h8000, 16'hFFFF, 4'b1111);
    repeat (5) tick();
    check("sat_neg_out", {16'h0, m_axis_tdata}, 32'hE000);
    set_all(16'h0000, 16'h0000, 4'b0000);
    repeat (5) tick();
    check("zero_out", {16'h0, m_axis_tdata}, 32'h0);
    check("flag_sticky", {31'h0, sat_flag}, 32'h1);
    sat_clear = 1'b1;
    tick();
    check("flag_cleared", {31'h0, sat_flag}, 32'h0);
    // Clear held while a saturating sample arrives: saturation wins.
    set_all(16'h7FFF, 16'hFFFF, 4'b1111);
    repeat (4) tick();
    check("clr_no_sat", {31'h0, sat_flag}, 32'h0);
    tick();
    check("clr_and_sat", {31'h0, sat_flag}, 32'h1);
    sat_clear = 1'b0;

    // Back to ch0 only at full level.
    set_all(16'd0, 16'd0, 4'b0001);
    smp[0] = 16'd1000;
    amp[0] = 16'd8192;
    repeat (5) tick();
    check("restore_out", {16'h0, m_axis_tdata}, 32'd1000);

    // Ramp-down, reversal, clamping and step=0 script.
    for (int r = 0; r < 20; r++) begin
      ramp_enable = (r_en[r] != 0);
      ramp_step   = 8'(r_stp[r]);
      tick();
      check($sformatf("ramp_state_r%0d", r + 1), {30'h0, ramp_state}, 32'(r_st[r]));
      check($sformatf("ramp_out_r%0d", r + 1), {16'h0, m_axis_tdata}, 32'(r_out[r]));
    end

    // Asynchronous reset while ON.
    aresetn = 1'b0;
    #1;
    check("arst_tdata", {16'h0, m_axis_tdata}, 32'h0);
    check("arst_tvalid", {31'h0, m_axis_tvalid}, 32'h0);
    check("arst_state", {30'h0, ramp_state}, 32'h0);
    check("arst_tready", {28'h0, s_axis_tready}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fourier_synthesizer_ramped.md
Name: fourier_synthesizer_ramped

Overview:
Parametrised successor of the four-channel DDS Fourier synthesizer. It weights N_CHANNELS signed DDS streams by unsigned per-channel amplitudes and sums them in a pipelined adder tree. The sum is scaled by a global soft-start/soft-stop ramp envelope, then shifted and saturated to DAC width. It sits between the per-channel DDS cores and the DAC output path, one instance per DAC.

Parameters:
N_CHANNELS, 4, number of DDS input channels (>=1)
AXIS_TDATA_WIDTH, 16, DDS sample width and output tdata width
CFG_DATA_WIDTH, 16, amplitude word width (unsigned)
DAC_WIDTH, 14, saturated output width
SHIFT, 13, arithmetic right shift applied after ramp scaling
RAMP_WIDTH, 16, ramp fractional bits; full scale = 2^RAMP_WIDTH

Ports:
clk  in  1  system clock, 125 MHz
aresetn  in  1  asynchronous active-low reset
s_axis_tdata  in  N_CHANNELS*AXIS_TDATA_WIDTH  packed signed DDS samples, channel 0 in LSBs
s_axis_tvalid  in  N_CHANNELS  per-channel valid
s_axis_tready  out  N_CHANNELS  all ones when aresetn=1, zeros in reset
amplitude  in  N_CHANNELS*CFG_DATA_WIDTH  packed unsigned per-channel amplitudes
ramp_enable  in  1  1 = ramp up / hold on, 0 = ramp down / hold off
ramp_step  in  RAMP_WIDTH  level increment/decrement per clk
sat_clear  in  1  clears sat_flag
ramp_state  out  2  IDLE=0, RAMP_UP=1, ON=2, RAMP_DOWN=3
sat_flag  out  1  sticky: set when any output sample saturates
m_axis_tdata  out  AXIS_TDATA_WIDTH  DAC sample, sign-extended from DAC_WIDTH
m_axis_tvalid  out  1  output valid

Behaviour:
- Reset (async assert, sync release): all pipeline registers 0, level 0, state IDLE, m_axis_tdata 0, m_axis_tvalid 0, sat_flag 0. Reset mid-ramp aborts instantly to level 0.
- Stage M (1 cycle): product = sample * {1'b0, amplitude}, width AXIS_TDATA_WIDTH+CFG_DATA_WIDTH+1; the product register loads 0 when tvalid=0 for that channel.
- Tree (T = ceil(log2 N_CHANNELS) cycles): pairwise registered adds, +1 bit per level. Odd leftovers are passed through registered. T=0 for N=1.
- Stage R (1 cycle): scaled = (tree_sum * level) >>> RAMP_WIDTH, using the level register value in the same cycle.
- Stage S (1 cycle): v = scaled >>> SHIFT. If v > 2^(DAC_WIDTH-1)-1, output the max and set sat_flag. If v < -2^(DAC_WIDTH-1), output the min and set sat_flag. Otherwise output v[DAC_WIDTH-1:0].
- Latency L = T+3 clk from sample to m_axis_tdata (5 for N=4).
- m_axis_tvalid: 0 for the first L cycles after reset release, then 1 permanently. Shift-register fill tracking.
- sat_clear: clears sat_flag. Simultaneous clear and new saturation leaves sat_flag=1.
- Ramp FSM, level unsigned RAMP_WIDTH+1 bits, range 0..2^RAMP_WIDTH:
  - IDLE: level=0. ramp_enable=1 -> RAMP_UP.
  - RAMP_UP: level = min(level+ramp_step, 2^RAMP_WIDTH). On reaching full -> ON. ramp_enable=0 -> RAMP_DOWN from the current level.
  - ON: level = full. ramp_enable=0 -> RAMP_DOWN.
  - RAMP_DOWN: level = max(level-ramp_step, 0). On reaching 0 -> IDLE. ramp_enable=1 -> RAMP_UP from the current level.
  - ramp_step=0: level holds and the state is unchanged.
  - A level change is visible at the output 2 cycles after the level register updates.

Decomposition:
- Shared package fourier_synth_pkg:
  - ramp state encodings.
  - clog2 function.
  - latency function L(N) = clog2(N)+3.
- One sub-module fs_ramp_ctrl:
  - contains the FSM and level register.
  - ports: clk, aresetn, ramp_enable, ramp_step, level, ramp_state.
- Multiply, tree and saturation stay in the top module, using a generate loop for the tree.

Test Plan:
All scenarios use N=4, W=16, CFG=16, DAC=14, SHIFT=13, RAMP_WIDTH=8.
1. Reset release with constant inputs -> tdata 0 and tvalid 0 for 5 cycles, then tvalid=1. Asserting aresetn=0 mid-ON -> tdata 0, tvalid 0, ramp_state 0 in the same cycle.
2. ch0 = 1000, amplitude 8192, others tvalid=0, ramp_enable=1, step=64 -> level 64, 128, 192, 256. Output 250, 500, 750, 1000. ramp_state goes 1 then 2 after 4 cycles.
3. From level 128, drop ramp_enable -> levels 64, 0, state IDLE. Re-assert at level 64 -> RAMP_UP continues 128, 192.
4. From level 128, step=200 -> level clamps to 256 and ramp_state=2 in one cycle. In RAMP_DOWN, step=200 from 128 -> 0 and IDLE.
5. All channels 32767, amplitude 65535, ON -> tdata 16'h1FFF, sat_flag=1. All channels -32768 -> tdata 16'hE000. sat_clear with no saturating sample -> sat_flag 0.
6. ch1 tvalid toggled 0/1 with ch1 = 2000, amplitude 8192, ON -> output alternates 0 and 2000, delayed 5 cycles.
